// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline forwarding/hazard logic: forwarding select
// encodings, multiply-freeze FSM states and the shadow-stage control flags.
package pipe_pkg;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } mul_state_e;

    // Control half of a shadow-stage record; the destination address is added by the
    // user because its width is a module parameter.
    typedef struct packed {
        logic valid;
        logic regwrite;
        logic memread;
        logic is_mul;
    } stage_flags_t;

endpackage

// File: rtl/fwd_match.sv
// Forwarding select for one source operand: EX/MEM producer first, then MEM/WB,
// otherwise the register file. Register 0 never forwards.
module fwd_match
    import pipe_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  used_i,
    input  logic [REG_ADDR_W-1:0] src_i,
    input  logic                  ex_wr_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  mem_wr_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_i,
    output logic [1:0]            sel_o
);

    // Priority compare against the two producer stages
    always_comb begin
        sel_o = FWD_RF;
        if (used_i && (src_i != {REG_ADDR_W{1'b0}})) begin
            if (ex_wr_i && (ex_rd_i == src_i)) begin
                sel_o = FWD_EXMEM;
            end else if (mem_wr_i && (mem_rd_i == src_i)) begin
                sel_o = FWD_MEMWB;
            end else begin
                sel_o = FWD_RF;
            end
        end else begin
            sel_o = FWD_RF;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard control for the 5-stage pipeline: shadow EX/MEM/WB tracking,
// registered per-operand forwarding selects, load-use stall, flush bubble, multiply freeze.
module fwd_hazard_unit
    import pipe_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2,
    parameter int MUL_LAT    = 3
) (
    input  logic                           clk,
    input  logic                           arst_n,
    input  logic                           id_valid_i,
    input  logic [NUM_SRC*REG_ADDR_W-1:0]  id_src_addr_i,
    input  logic [NUM_SRC-1:0]             id_src_used_i,
    input  logic [REG_ADDR_W-1:0]          id_rd_i,
    input  logic                           id_reg_write_i,
    input  logic                           id_mem_read_i,
    input  logic                           id_is_mul_i,
    input  logic                           flush_i,
    output logic [2*NUM_SRC-1:0]           fwd_sel_o,
    output logic                           stall_o,
    output logic                           ex_hold_o,
    output logic                           bubble_ex_o,
    output logic                           bubble_mem_o,
    output logic                           mul_busy_o
);

    localparam int CNT_LOAD = (MUL_LAT > 2) ? MUL_LAT - 2 : 0;
    localparam int CNT_W    = (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;

    typedef struct packed {
        stage_flags_t            f;
        logic [REG_ADDR_W-1:0]   rd;
    } stage_t;

    stage_t               ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic [2*NUM_SRC-1:0] fwd_sel_q, fwd_sel_d, fwd_sel_s;
    mul_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ex_wr_s, mem_wr_s, src_hit_s, load_use_s;
    logic                 mul_enter_s, freeze_s, flush_eff_s, id_take_s;
    logic                 unused_s;

    assign ex_wr_s  = ex_q.f.valid & ex_q.f.regwrite;
    assign mem_wr_s = mem_q.f.valid & mem_q.f.regwrite;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_match
        fwd_match #(.REG_ADDR_W(REG_ADDR_W)) u_match (
            .used_i   (id_src_used_i[k]),
            .src_i    (id_src_addr_i[k*REG_ADDR_W +: REG_ADDR_W]),
            .ex_wr_i  (ex_wr_s),
            .ex_rd_i  (ex_q.rd),
            .mem_wr_i (mem_wr_s),
            .mem_rd_i (mem_q.rd),
            .sel_o    (fwd_sel_s[2*k +: 2])
        );
    end

    // Does any used ID operand name the EX destination
    always_comb begin
        src_hit_s = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (id_src_used_i[k] && (id_src_addr_i[k*REG_ADDR_W +: REG_ADDR_W] == ex_q.rd)) begin
                src_hit_s = 1'b1;
            end else begin
                src_hit_s = src_hit_s;
            end
        end
    end

    assign load_use_s  = ex_q.f.valid & ex_q.f.memread & (ex_q.rd != {REG_ADDR_W{1'b0}}) & src_hit_s;
    assign mul_enter_s = (MUL_LAT > 1) && (state_q == IDLE) && ex_q.f.valid && ex_q.f.is_mul;
    // The multiply stays put through its first cycle and every busy cycle but the last,
    // so it leaves EX after exactly MUL_LAT cycles.
    assign freeze_s    = mul_enter_s | ((state_q == MUL_BUSY) && (cnt_q != {CNT_W{1'b0}}));
    assign flush_eff_s = flush_i & (state_q == IDLE);

    assign stall_o      = freeze_s | (load_use_s & ~flush_eff_s);
    assign ex_hold_o    = freeze_s;
    assign bubble_mem_o = freeze_s;
    assign bubble_ex_o  = ~freeze_s & (flush_eff_s | load_use_s);
    assign mul_busy_o   = (state_q == MUL_BUSY);
    assign fwd_sel_o    = fwd_sel_q;
    assign id_take_s    = id_valid_i & ~bubble_ex_o;

    // Shadow pipeline advance and forwarding-select capture
    always_comb begin
        ex_d      = ex_q;
        mem_d     = '0;
        wb_d      = mem_q;
        fwd_sel_d = fwd_sel_q;
        if (!freeze_s) begin
            mem_d     = ex_q;
            fwd_sel_d = id_take_s ? fwd_sel_s : {2*NUM_SRC{1'b0}};
            if (id_take_s) begin
                ex_d.f.valid    = 1'b1;
                ex_d.f.regwrite = id_reg_write_i;
                ex_d.f.memread  = id_mem_read_i;
                ex_d.f.is_mul   = id_is_mul_i;
                ex_d.rd         = id_rd_i;
            end else begin
                ex_d = '0;
            end
        end else begin
            ex_d = ex_q;
        end
    end

    // Multiply freeze FSM and its cycle counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (mul_enter_s) begin
                    state_d = MUL_BUSY;
                    cnt_d   = CNT_W'(CNT_LOAD);
                end else begin
                    state_d = IDLE;
                end
            end
            MUL_BUSY: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1'b1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            fwd_sel_q <= {2*NUM_SRC{1'b0}};
            state_q   <= IDLE;
            cnt_q     <= {CNT_W{1'b0}};
        end else begin
            ex_q      <= ex_d;
            mem_q     <= mem_d;
            wb_q      <= wb_d;
            fwd_sel_q <= fwd_sel_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
        end
    end

    // WB is tracked for completeness; the write-before-read regfile means nothing consumes it.
    assign unused_s = ^{wb_q, mem_q.f.memread, mem_q.f.is_mul};

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: two instances (3 operands / MUL_LAT 3 and 2 operands /
// MUL_LAT 1) share stimulus and are checked each cycle against an in-flight model.
module tb_fwd_hazard_unit;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        id_valid = 1'b0, id_rw = 1'b0, id_mr = 1'b0, id_mul = 1'b0, flush = 1'b0;
    logic [4:0]  id_rd = 5'd0;
    logic [14:0] id_src = 15'd0;
    logic [2:0]  id_used = 3'd0;

    logic [5:0]  fwd_a;
    logic [3:0]  fwd_b;
    logic        stall_a, hold_a, bex_a, bmem_a, busy_a;
    logic        stall_b, hold_b, bex_b, bmem_b, busy_b;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.REG_ADDR_W(5), .NUM_SRC(3), .MUL_LAT(3)) dut_a (
        .clk(clk), .arst_n(arst_n), .id_valid_i(id_valid), .id_src_addr_i(id_src),
        .id_src_used_i(id_used), .id_rd_i(id_rd), .id_reg_write_i(id_rw),
        .id_mem_read_i(id_mr), .id_is_mul_i(id_mul), .flush_i(flush),
        .fwd_sel_o(fwd_a), .stall_o(stall_a), .ex_hold_o(hold_a),
        .bubble_ex_o(bex_a), .bubble_mem_o(bmem_a), .mul_busy_o(busy_a)
    );

    fwd_hazard_unit #(.REG_ADDR_W(5), .NUM_SRC(2), .MUL_LAT(1)) dut_b (
        .clk(clk), .arst_n(arst_n), .id_valid_i(id_valid), .id_src_addr_i(id_src[9:0]),
        .id_src_used_i(id_used[1:0]), .id_rd_i(id_rd), .id_reg_write_i(id_rw),
        .id_mem_read_i(id_mr), .id_is_mul_i(id_mul), .flush_i(flush),
        .fwd_sel_o(fwd_b), .stall_o(stall_b), .ex_hold_o(hold_b),
        .bubble_ex_o(bex_b), .bubble_mem_o(bmem_b), .mul_busy_o(busy_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: what occupies EX and MEM, and for how long EX has held it.
    int LAT[2] = '{3, 1};
    int NS[2]  = '{3, 2};
    bit ex_v[2], ex_rw[2], ex_mr[2], ex_mul[2];
    int ex_rd[2];
    bit mem_v[2], mem_rw[2];
    int mem_rd[2];
    int occ[2];
    int exp_fwd[2];
    bit exp_stall_a = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int src_at(int k);
        return int'(id_src[k*5 +: 5]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            ex_v[i] = 0; ex_rw[i] = 0; ex_mr[i] = 0; ex_mul[i] = 0; ex_rd[i] = 0;
            mem_v[i] = 0; mem_rw[i] = 0; mem_rd[i] = 0;
            occ[i] = 0; exp_fwd[i] = 0;
        end
        exp_stall_a = 1'b0;
    endtask

    function automatic int fwd_of(int i);
        int r = 0;
        for (int k = 0; k < NS[i]; k++) begin
            int s = src_at(k);
            int sel = 0;
            if (id_used[k] && s != 0) begin
                if (ex_v[i] && ex_rw[i] && ex_rd[i] == s) sel = 2;
                else if (mem_v[i] && mem_rw[i] && mem_rd[i] == s) sel = 1;
            end
            r = r | (sel << (2 * k));
        end
        return r;
    endfunction

    task automatic check_all_zero(input string pfx);
        check({pfx, ".a.fwd"}, 32'(fwd_a), 32'd0);
        check({pfx, ".a.stall"}, 32'(stall_a), 32'd0);
        check({pfx, ".a.hold"}, 32'(hold_a), 32'd0);
        check({pfx, ".a.bex"}, 32'(bex_a), 32'd0);
        check({pfx, ".a.bmem"}, 32'(bmem_a), 32'd0);
        check({pfx, ".a.busy"}, 32'(busy_a), 32'd0);
        check({pfx, ".b.fwd"}, 32'(fwd_b), 32'd0);
        check({pfx, ".b.stall"}, 32'(stall_b), 32'd0);
        check({pfx, ".b.busy"}, 32'(busy_b), 32'd0);
    endtask

    // One clock: check every output at the falling edge, then advance the model at the rising edge.
    task automatic step();
        bit fz[2], bx[2];
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            bit busy, freeze, lu, fe, st;
            string nm = (i == 0) ? "a" : "b";
            busy   = ex_v[i] && ex_mul[i] && LAT[i] > 1 && occ[i] >= 2;
            freeze = ex_v[i] && ex_mul[i] && occ[i] < LAT[i];
            lu = 0;
            if (ex_v[i] && ex_mr[i] && ex_rd[i] != 0)
                for (int k = 0; k < NS[i]; k++)
                    if (id_used[k] && src_at(k) == ex_rd[i]) lu = 1;
            fe = flush && !busy;
            bx[i] = !freeze && (fe || lu);
            st = freeze || (lu && !fe);
            fz[i] = freeze;
            if (i == 0) exp_stall_a = st;
            check({nm, ".fwd"},   (i == 0) ? 32'(fwd_a)  : 32'(fwd_b),  32'(exp_fwd[i]));
            check({nm, ".stall"}, (i == 0) ? 32'(stall_a) : 32'(stall_b), 32'(st));
            check({nm, ".hold"},  (i == 0) ? 32'(hold_a) : 32'(hold_b), 32'(freeze));
            check({nm, ".bex"},   (i == 0) ? 32'(bex_a)  : 32'(bex_b),  32'(bx[i]));
            check({nm, ".bmem"},  (i == 0) ? 32'(bmem_a) : 32'(bmem_b), 32'(freeze));
            check({nm, ".busy"},  (i == 0) ? 32'(busy_a) : 32'(busy_b), 32'(busy));
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (fz[i]) begin
                occ[i]++;
                mem_v[i] = 0; mem_rw[i] = 0; mem_rd[i] = 0;
            end else begin
                bit take = id_valid && !bx[i];
                int nf = take ? fwd_of(i) : 0;
                mem_v[i] = ex_v[i]; mem_rw[i] = ex_rw[i]; mem_rd[i] = ex_rd[i];
                ex_v[i] = take; ex_rw[i] = take && id_rw; ex_mr[i] = take && id_mr;
                ex_mul[i] = take && id_mul; ex_rd[i] = take ? int'(id_rd) : 0;
                occ[i] = 1;
                exp_fwd[i] = nf;
            end
        end
        #1;
    endtask

    task automatic ins(input bit v, input int s0, input int s1, input int s2, input bit [2:0] u,
                       input int rd, input bit rw, input bit mr, input bit mul, input bit fl);
        id_valid = v; id_src = {5'(s2), 5'(s1), 5'(s0)}; id_used = u;
        id_rd = 5'(rd); id_rw = rw; id_mr = mr; id_mul = mul; flush = fl;
        step();
    endtask

    initial begin
        model_reset();
        #12;
        check_all_zero("reset");
        arst_n = 1'b1;
        @(posedge clk);
        #1;

        // EX/MEM forward to a dependent ALU op
        ins(1, 1, 2, 0, 3'b011, 3, 1, 0, 0, 0);
        ins(1, 3, 4, 0, 3'b011, 7, 1, 0, 0, 0);
        ins(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
        // r3 in both EX and MEM, then the same with r0
        ins(1, 1, 1, 0, 3'b011, 3, 1, 0, 0, 0);
        ins(1, 2, 2, 0, 3'b011, 3, 1, 0, 0, 0);
        ins(1, 5, 3, 0, 3'b011, 8, 1, 0, 0, 0);
        ins(1, 1, 1, 0, 3'b011, 0, 1, 0, 0, 0);
        ins(1, 2, 2, 0, 3'b011, 0, 1, 0, 0, 0);
        ins(1, 5, 0, 0, 3'b011, 8, 1, 0, 0, 0);
        // load-use: one stall cycle, then MEM/WB forward; then unused operand
        ins(1, 1, 0, 0, 3'b001, 5, 1, 1, 0, 0);
        ins(1, 5, 2, 0, 3'b011, 6, 1, 0, 0, 0);
        ins(1, 5, 2, 0, 3'b011, 6, 1, 0, 0, 0);
        ins(1, 1, 0, 0, 3'b001, 5, 1, 1, 0, 0);
        ins(1, 5, 2, 0, 3'b010, 6, 1, 0, 0, 0);
        // multiply freeze with a dependent op held in ID
        ins(1, 1, 2, 0, 3'b011, 9, 1, 0, 1, 0);
        ins(1, 9, 0, 0, 3'b001, 10, 1, 0, 0, 0);
        ins(1, 9, 0, 0, 3'b001, 10, 1, 0, 0, 0);
        ins(1, 9, 0, 0, 3'b001, 10, 1, 0, 0, 0);
        ins(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
        // flush coincident with load-use
        ins(1, 1, 0, 0, 3'b001, 5, 1, 1, 0, 0);
        ins(1, 5, 0, 0, 3'b001, 6, 1, 0, 0, 1);
        // third operand from MEM/WB
        ins(1, 1, 1, 1, 3'b111, 6, 1, 0, 0, 0);
        ins(1, 1, 1, 1, 3'b111, 7, 0, 0, 0, 0);
        ins(1, 2, 2, 6, 3'b111, 8, 1, 0, 0, 0);
        ins(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);

        // asynchronous reset in the middle of a multiply freeze
        ins(1, 1, 2, 0, 3'b011, 4, 1, 0, 1, 0);
        ins(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
        #2;
        arst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        model_reset();
        @(negedge clk);
        #2;
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        ins(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);

        // randomized traffic on a small register set to provoke hazards
        for (int n = 0; n < 1500; n++) begin
            if (!exp_stall_a) begin
                int kind = int'($urandom_range(7));
                id_valid = ($urandom_range(7) != 0);
                id_src   = 15'($urandom());
                for (int k = 0; k < 3; k++) id_src[k*5 +: 5] = 5'($urandom_range(7));
                id_used  = 3'($urandom_range(7));
                id_rd    = 5'($urandom_range(7));
                id_rw    = ($urandom_range(5) != 0);
                id_mul   = (kind == 0);
                id_mr    = (kind == 1 || kind == 2);
            end
            flush = ($urandom_range(9) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
